// File: rtl/uart_frame_pkg.sv
// Package: uart_frame_pkg
// Frame constants and FSM state type shared by the frame transmitter and receiver.
// A frame is EB 9C followed by eight payload bytes, LSB first. When
// FRAME_TX_CHKSUM_EN is defined, a checksum byte follows.
package uart_frame_pkg;

  localparam logic [7:0] FRAME_HEAD_FB       = 8'hEB;
  localparam logic [7:0] FRAME_HEAD_SB       = 8'h9C;
  localparam int         FRAME_PAYLOAD_BYTES = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD_FB,
    S_HEAD_SB,
    S_PAYLOAD,
    S_CHK,
    S_GAP
  } frame_state_e;

  // Payload byte k is bits [8k+7:8k] of the command word.
  function automatic logic [7:0] payload_byte(input logic [63:0] word, input logic [2:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Interface: uart_frame_tx_if
// Carries the command-word handshake from the host and the byte handshake to the UART serialiser.
// The transmitter connects to the slave modport. The host and serialiser side connects to the master modport.
interface uart_frame_tx_if;

  logic [63:0] frame_word_in;
  logic        frame_word_ena;
  logic        frame_word_rdy;
  logic [7:0]  tx_data_out;
  logic        tx_data_ena;
  logic        tx_data_rdy;

  modport master (
    output frame_word_in, frame_word_ena, tx_data_rdy,
    input  frame_word_rdy, tx_data_out, tx_data_ena
  );

  modport slave (
    input  frame_word_in, frame_word_ena, tx_data_rdy,
    output frame_word_rdy, tx_data_out, tx_data_ena
  );

endinterface

// File: rtl/uart_frame_tx.sv
// Module: uart_frame_tx
// Serialises one accepted 64-bit command word into EB 9C + 8 payload bytes (LSB first).
// An idle gap of GAP_CYCLES cycles follows each frame.
// Optional feature macro: FRAME_TX_CHKSUM_EN adds a trailing byte. The byte makes the sum of all 11 bytes equal to 0.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int GAP_CYCLES = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_frame_tx_if.slave   bus,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int             GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [2:0]     LAST_IDX = 3'(FRAME_PAYLOAD_BYTES - 1);

  frame_state_e     r_state;
  frame_state_e     w_state_next;
  logic [63:0]      r_word;
  logic [2:0]       r_idx;
  logic [GAP_W-1:0] r_gap;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rdy;
  logic [7:0]       w_tx_byte;
  logic             w_tx_ena;
  logic             w_accept;
  logic             w_cons;
  logic             w_frame_done;
`ifdef FRAME_TX_CHKSUM_EN
  logic [7:0]       r_acc;
`endif

  // r_rdy is only ever high in IDLE, so it alone qualifies the accept.
  assign w_accept = bus.frame_word_ena && r_rdy;
  assign w_cons   = w_tx_ena && bus.tx_data_rdy;
  // Leaving a byte state for GAP or IDLE only happens on the last byte of a frame.
  assign w_frame_done = w_cons && ((w_state_next == S_GAP) || (w_state_next == S_IDLE));

  // Next state, presented byte and its valid flag, all decoded from the current state.
  always_comb begin
    w_state_next = r_state;
    w_tx_ena     = 1'b0;
    w_tx_byte    = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_HEAD_FB;
      end
      S_HEAD_FB: begin
        w_tx_ena  = 1'b1;
        w_tx_byte = FRAME_HEAD_FB;
        if (bus.tx_data_rdy) w_state_next = S_HEAD_SB;
      end
      S_HEAD_SB: begin
        w_tx_ena  = 1'b1;
        w_tx_byte = FRAME_HEAD_SB;
        if (bus.tx_data_rdy) w_state_next = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        w_tx_ena  = 1'b1;
        w_tx_byte = payload_byte(r_word, r_idx);
        if (bus.tx_data_rdy && (r_idx == LAST_IDX)) begin
`ifdef FRAME_TX_CHKSUM_EN
          w_state_next = S_CHK;
`else
          if (GAP_CYCLES == 0) w_state_next = S_IDLE;
          else                 w_state_next = S_GAP;
`endif
        end
      end
`ifdef FRAME_TX_CHKSUM_EN
      S_CHK: begin
        w_tx_ena  = 1'b1;
        w_tx_byte = 8'h00 - r_acc;
        if (bus.tx_data_rdy) begin
          if (GAP_CYCLES == 0) w_state_next = S_IDLE;
          else                 w_state_next = S_GAP;
        end
      end
`endif
      S_GAP: begin
        if (r_gap == GAP_LAST) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register, word latch, payload index, gap counter and sent-frame counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_idx   <= '0;
      r_gap   <= '0;
      r_cnt   <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_rdy   <= (w_state_next == S_IDLE);
      if (w_accept) begin
        r_word <= bus.frame_word_in;
        r_idx  <= '0;
      end else if (w_cons && (r_state == S_PAYLOAD)) begin
        r_idx <= r_idx + 3'd1;
      end
      if (r_state == S_GAP) r_gap <= r_gap + 1'b1;
      else                  r_gap <= '0;
      if (w_frame_done) r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef FRAME_TX_CHKSUM_EN
  // Running byte sum of the frame. It is cleared on accept, so the checksum state can emit its negation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
    end else if (w_cons) begin
      r_acc <= r_acc + w_tx_byte;
    end
  end
`endif

  assign bus.frame_word_rdy = r_rdy;
  assign bus.tx_data_out    = w_tx_byte;
  assign bus.tx_data_ena    = w_tx_ena;
  assign busy               = (r_state != S_IDLE);
  assign frame_cnt          = r_cnt;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Testbench: tb_uart_frame_tx
// Sends table-driven and random command words. Each captured byte stream is compared against a
// frame built from the word. The bench also checks latency, byte hold under back-pressure,
// gap length, counter wrap (CNT_W=4) and an abort by reset during the payload.
module tb_uart_frame_tx;

  localparam int GAP = 16;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy;
  logic [CW-1:0] frame_cnt;

  uart_frame_tx_if bus();

  uart_frame_tx #(.GAP_CYCLES(GAP), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            rdy_mode = 0;
  int            frame_no = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [7:0]    got_q[$];

  typedef struct {
    logic [63:0] word;
    int          mode;     // 0: rdy always 1, 1: rdy 1-of-3, 2: random rdy
    logic [7:0]  exp_chk;  // hand-computed checksum byte for this word
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock. Bytes are recorded when they are consumed at this edge. tx_data_rdy is then driven for the next cycle.
  task automatic tick();
    logic       stall;
    logic [7:0] held;
    stall = rst_n && bus.tx_data_ena && !bus.tx_data_rdy;
    held  = bus.tx_data_out;
    if (rst_n && bus.tx_data_ena && bus.tx_data_rdy) got_q.push_back(bus.tx_data_out);
    @(posedge clk);
    #1;
    cyc++;
    if (stall) begin
      check("hold_ena", {63'd0, bus.tx_data_ena}, 64'd1);
      check("hold_byte", {56'd0, bus.tx_data_out}, {56'd0, held});
    end
    case (rdy_mode)
      0:       bus.tx_data_rdy = 1'b1;
      1:       bus.tx_data_rdy = (cyc % 3 == 0);
      default: bus.tx_data_rdy = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Reference frame: header, payload bytes LSB first, optional negated byte sum.
  function automatic void build_frame(input logic [63:0] w, output logic [7:0] q[$]);
    int sum;
    q = {};
    q.push_back(8'hEB);
    q.push_back(8'h9C);
    for (int k = 0; k < 8; k++) q.push_back(w[8*k +: 8]);
    sum = 0;
    foreach (q[i]) sum += q[i];
`ifdef FRAME_TX_CHKSUM_EN
    q.push_back(8'((256 - (sum % 256)) % 256));
`endif
  endfunction

  task automatic send_frame(input logic [63:0] w, input int mode, input logic [7:0] exp_chk, input bit chk_known);
    logic [7:0] exp_q[$];
    int t;
    int g;
    int bad;
    build_frame(w, exp_q);
    rdy_mode = mode;
    got_q = {};
    t = 0;
    while (!bus.frame_word_rdy && t < 200) begin tick(); t++; end
    check("word_rdy_wait", {63'd0, bus.frame_word_rdy}, 64'd1);
    bus.frame_word_in  = w;
    bus.frame_word_ena = 1'b1;
    tick();
    bus.frame_word_ena = 1'b0;
    check("first_byte_ena", {63'd0, bus.tx_data_ena}, 64'd1);
    check("first_byte_eb", {56'd0, bus.tx_data_out}, 64'hEB);
    check("busy_on_accept", {63'd0, busy}, 64'd1);
    check("rdy_drop", {63'd0, bus.frame_word_rdy}, 64'd0);
    t = 0;
    while (got_q.size() < exp_q.size() && t < 500) begin
      // Junk words offered while busy must be ignored.
      bus.frame_word_in  = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.frame_word_ena = ($urandom_range(0, 3) == 0);
      tick();
      t++;
    end
    bus.frame_word_ena = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    check("byte_count", 64'(got_q.size()), 64'(exp_q.size()));
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    if (bad >= 0) check($sformatf("byte_%0d", bad), {56'd0, got_q[bad]}, {56'd0, exp_q[bad]});
    else          check("byte_seq", 64'd0, 64'd0 + 64'(bad + 1));
`ifdef FRAME_TX_CHKSUM_EN
    if (chk_known && got_q.size() == 11) check("chk_byte", {56'd0, got_q[10]}, {56'd0, exp_chk});
`else
    if (chk_known) check("no_chk_len", 64'(got_q.size()), 64'd10);
`endif
    check("ena_low_in_gap", {63'd0, bus.tx_data_ena}, 64'd0);
    check("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
    g = 0;
    while (!bus.frame_word_rdy && g < 100) begin tick(); g++; end
    check("gap_len", 64'(g), 64'(GAP));
    check("busy_after_gap", {63'd0, busy}, 64'd0);
    $display("frame %0d word=%h mode=%0d bytes=%0d gap=%0d cnt=%0d",
             frame_no, w, mode, got_q.size(), g, frame_cnt);
    frame_no++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    vecs[0] = '{64'h02002000_01123456, 0, 8'hBA};
    vecs[1] = '{64'h02002000_01123456, 1, 8'hBA};
    vecs[2] = '{64'h00000000_00000000, 2, 8'h79};
    vecs[3] = '{64'hFFFFFFFF_FFFFFFFF, 0, 8'h81};
    vecs[4] = '{64'h01020304_05060708, 1, 8'h55};

    bus.frame_word_in  = '0;
    bus.frame_word_ena = 1'b0;
    bus.tx_data_rdy    = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_rdy", {63'd0, bus.frame_word_rdy}, 64'd0);
    check("rst_ena", {63'd0, bus.tx_data_ena}, 64'd0);
    check("rst_data", {56'd0, bus.tx_data_out}, 64'h00);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_cnt", 64'(frame_cnt), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rdy_after_release", {63'd0, bus.frame_word_rdy}, 64'd1);

    foreach (vecs[i]) send_frame(vecs[i].word, vecs[i].mode, vecs[i].exp_chk, 1'b1);

    // Reset while payload byte 3 is on the bus: the frame is abandoned.
    w = 64'h1122334455667788;
    rdy_mode = 0;
    bus.frame_word_in  = w;
    bus.frame_word_ena = 1'b1;
    tick();
    bus.frame_word_ena = 1'b0;
    got_q = {};
    for (int i = 0; i < 100 && got_q.size() < 5; i++) tick();
    check("abort_at_idx3", {56'd0, bus.tx_data_out}, {56'd0, w[31:24]});
    rst_n = 1'b0;
    tick();
    check("abort_ena", {63'd0, bus.tx_data_ena}, 64'd0);
    check("abort_cnt", 64'(frame_cnt), 64'd0);
    check("abort_rdy_low", {63'd0, bus.frame_word_rdy}, 64'd0);
    rst_n = 1'b1;
    exp_cnt = '0;
    tick();
    check("abort_rdy_release", {63'd0, bus.frame_word_rdy}, 64'd1);
    got_q = {};
    repeat (20) tick();
    check("abort_no_bytes", 64'(got_q.size()), 64'd0);
    $display("abort word=%h at payload idx 3, cnt=%0d", w, frame_cnt);

    // 16 random frames exercise the 4-bit counter wrap from 15 back to 0.
    for (int i = 0; i < 16; i++) begin
      w = {$urandom, $urandom};
      send_frame(w, int'($urandom_range(0, 2)), 8'h00, 1'b0);
    end
    check("cnt_wrapped", 64'(frame_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
